// File: rtl/mic_stream_sched.sv
`timescale 1ns/1ps
// mic_stream_sched: pops one sample from every mic FIFO per set and streams framed bytes to the UART.
// Optional MIC_SCHED_CHKSUM_EN appends an XOR checksum of each frame's payload bytes.
module mic_stream_sched #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned FRAME_LEN = 256,
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic [NUM_CH-1:0]          fifo_empty,
    output logic [NUM_CH-1:0]          fifo_rd_en,
    input  logic [NUM_CH*SAMPLE_W-1:0] fifo_q,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic [15:0]                frame_cnt
);
    localparam int unsigned BUF_W     = NUM_CH * SAMPLE_W;
    localparam int unsigned SET_BYTES = BUF_W / 8;
    localparam int unsigned IDX_W     = ($clog2(SET_BYTES + 1) < 3) ? 3 : $clog2(SET_BYTES + 1);
    localparam int unsigned SET_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WAIT, S_POP, S_LATCH, S_SEND, S_END
    } state_t;

    state_t             state, state_nxt;
    logic               armed;
    logic [IDX_W-1:0]   byte_idx, byte_idx_nxt;
    logic [SET_W-1:0]   set_cnt, set_cnt_nxt;
    logic [15:0]        frame_cnt_nxt;
    logic [BUF_W-1:0]   shift_buf, shift_nxt, latch_buf;
    logic [7:0]         tx_data_nxt, hdr_byte;
    logic               tx_valid_nxt;
    logic               can_load_c;

`ifdef MIC_SCHED_CHKSUM_EN
    logic [7:0]         chk_acc;
    logic               pay_load_c;
`endif

    // Output byte register may be (re)loaded when empty or being accepted this cycle
    assign can_load_c = !tx_valid || tx_ready;

    // Reorder so ch0 lands in the MSBs: bytes then leave MSB-first in channel order
    always_comb begin
        latch_buf = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            latch_buf[(NUM_CH-1-c)*SAMPLE_W +: SAMPLE_W] = fifo_q[c*SAMPLE_W +: SAMPLE_W];
    end

    always_comb begin
        case (byte_idx)
            IDX_W'(0): hdr_byte = SYNC_WORD[15:8];
            IDX_W'(1): hdr_byte = SYNC_WORD[7:0];
            IDX_W'(2): hdr_byte = frame_cnt[15:8];
            default:   hdr_byte = frame_cnt[7:0];
        endcase
    end

    always_comb begin
        state_nxt     = state;
        byte_idx_nxt  = byte_idx;
        set_cnt_nxt   = set_cnt;
        frame_cnt_nxt = frame_cnt;
        shift_nxt     = shift_buf;
        tx_data_nxt   = tx_data;
        tx_valid_nxt  = tx_valid;
        case (state)
            S_IDLE: if (armed) state_nxt = S_HDR;
            S_HDR: begin
                if (can_load_c) begin
                    if (byte_idx != IDX_W'(4)) begin
                        tx_data_nxt  = hdr_byte;
                        tx_valid_nxt = 1'b1;
                        byte_idx_nxt = byte_idx + IDX_W'(1);
                    end else begin
                        tx_valid_nxt = 1'b0;
                        byte_idx_nxt = '0;
                        state_nxt    = S_WAIT;
                    end
                end
            end
            S_WAIT: if (fifo_empty == '0) state_nxt = S_POP;
            S_POP:  state_nxt = S_LATCH;
            S_LATCH: begin
                tx_data_nxt  = latch_buf[BUF_W-1 -: 8];
                tx_valid_nxt = 1'b1;
                shift_nxt    = latch_buf << 8;
                byte_idx_nxt = IDX_W'(1);
                state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (can_load_c) begin
                    if (byte_idx != IDX_W'(SET_BYTES)) begin
                        tx_data_nxt  = shift_buf[BUF_W-1 -: 8];
                        tx_valid_nxt = 1'b1;
                        shift_nxt    = shift_buf << 8;
                        byte_idx_nxt = byte_idx + IDX_W'(1);
                    end else begin
                        tx_valid_nxt = 1'b0;
                        byte_idx_nxt = '0;
                        if (set_cnt == SET_W'(FRAME_LEN - 1)) begin
                            state_nxt = S_END;
                        end else begin
                            set_cnt_nxt = set_cnt + SET_W'(1);
                            state_nxt   = S_WAIT;
                        end
                    end
                end
            end
`ifdef MIC_SCHED_CHKSUM_EN
            S_END: begin
                if (can_load_c) begin
                    if (byte_idx == '0) begin
                        tx_data_nxt  = chk_acc;
                        tx_valid_nxt = 1'b1;
                        byte_idx_nxt = IDX_W'(1);
                    end else begin
                        tx_valid_nxt  = 1'b0;
                        byte_idx_nxt  = '0;
                        frame_cnt_nxt = frame_cnt + 16'd1;
                        set_cnt_nxt   = '0;
                        state_nxt     = armed ? S_HDR : S_IDLE;
                    end
                end
            end
`else
            S_END: begin
                frame_cnt_nxt = frame_cnt + 16'd1;
                set_cnt_nxt   = '0;
                state_nxt     = armed ? S_HDR : S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            byte_idx   <= '0;
            set_cnt    <= '0;
            frame_cnt  <= '0;
            shift_buf  <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            fifo_rd_en <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_idx   <= byte_idx_nxt;
            set_cnt    <= set_cnt_nxt;
            frame_cnt  <= frame_cnt_nxt;
            shift_buf  <= shift_nxt;
            tx_data    <= tx_data_nxt;
            tx_valid   <= tx_valid_nxt;
            fifo_rd_en <= (state_nxt == S_POP) ? {NUM_CH{1'b1}} : '0;
            busy       <= (state_nxt != S_IDLE);
        end
    end

    // Stop wins over a simultaneous start
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  armed <= 1'b0;
        else if (stop)   armed <= 1'b0;
        else if (start)  armed <= 1'b1;
    end

`ifdef MIC_SCHED_CHKSUM_EN
    assign pay_load_c = (state == S_LATCH) ||
                        (state == S_SEND && can_load_c && byte_idx != IDX_W'(SET_BYTES));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)          chk_acc <= '0;
        else if (state == S_HDR) chk_acc <= '0;
        else if (pay_load_c)     chk_acc <= chk_acc ^ tx_data_nxt;
    end
`endif

endmodule

// File: tb/tb_mic_stream_sched.sv
`timescale 1ns/1ps
// Bench for mic_stream_sched: FIFO and UART are modelled here; the byte stream is checked
// against an expected-frame queue built from headers, sample sets and frame ends.
module tb_mic_stream_sched;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tx_ready = 1'b1;
    logic [1:0]  fifo_empty = 2'b11;
    logic [1:0]  fifo_rd_en;
    logic [31:0] fifo_q = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic [15:0] frame_cnt;

    mic_stream_sched #(
        .NUM_CH(2), .SAMPLE_W(16), .FRAME_LEN(2), .SYNC_WORD(16'hA55A)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_q(fifo_q),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #8 sys_clk = ~sys_clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          xfers = 0;
    int          rd_cnt = 0;
    int          ready_mode = 0;
    logic [15:0] fq0[$];
    logic [15:0] fq1[$];
    logic [7:0]  exp_q[$];
    logic [15:0] exp_fc = '0;
    logic [7:0]  chk_acc = '0;
    logic        have_prev = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic upd_empty();
        fifo_empty = {fq1.size() == 0, fq0.size() == 0};
    endtask

    task automatic exp_payload(input logic [15:0] s);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
        chk_acc = chk_acc ^ s[15:8] ^ s[7:0];
    endtask

    task automatic push_set(input logic [15:0] c0, input logic [15:0] c1);
        fq0.push_back(c0);
        fq1.push_back(c1);
        upd_empty();
        exp_payload(c0);
        exp_payload(c1);
    endtask

    task automatic exp_header();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(exp_fc[15:8]);
        exp_q.push_back(exp_fc[7:0]);
        chk_acc = '0;
    endtask

    task automatic exp_end();
`ifdef MIC_SCHED_CHKSUM_EN
        exp_q.push_back(chk_acc);
`endif
        exp_fc = exp_fc + 16'd1;
    endtask

    // One clock: observe mid-cycle, then apply FIFO pops and new inputs just after the edge
    task automatic cyc();
        logic [1:0] pop_mask;
        logic [7:0] e;
        @(negedge sys_clk);
        if (have_prev && prev_valid && !prev_ready) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (fifo_rd_en != 2'b00) begin
            rd_cnt++;
            chk("rd_en_all", 32'(fifo_rd_en), 32'h3);
            chk("rd_en_nonempty", 32'(fifo_empty), 32'h0);
        end
        if (tx_valid && tx_ready) begin
            xfers++;
            chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stream_byte", 32'(tx_data), 32'(e));
            end
        end
        have_prev  = 1'b1;
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
        pop_mask   = fifo_rd_en;
        @(posedge sys_clk);
        #1;
        if (pop_mask[0] && fq0.size() != 0) fifo_q[15:0]  = fq0.pop_front();
        if (pop_mask[1] && fq1.size() != 0) fifo_q[31:16] = fq1.pop_front();
        upd_empty();
        start = 1'b0;
        stop  = 1'b0;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 3) != 0);
            default: tx_ready = 1'b0;
        endcase
    endtask

    task automatic wait_exp(input string tag, input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() > target; i++) cyc();
        chk(tag, 32'(exp_q.size() > target), 32'd0);
    endtask

    task automatic wait_xfers(input string tag, input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && xfers < target; i++) cyc();
        chk(tag, 32'(xfers >= target), 32'd1);
    endtask

    initial begin
        int          mark;
        int          r0;
        logic [15:0] v0;
        logic [15:0] v1;

        // Reset values
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        sys_rst_n = 1'b1;
        cyc();

        // First frame with known samples, then next header while still armed
        exp_header();
        push_set(16'h1234, 16'h9ABC);
        push_set(16'h5678, 16'hDEF0);
        exp_end();
        exp_header();
        start = 1'b1;
        wait_exp("frame0_done", 0, 300);
        chk("frame_cnt_1", 32'(frame_cnt), 32'd1);
        chk("busy_in_wait", 32'(busy), 32'd1);

        // ch1 empty: no pop and nothing sent; then one pop once ch1 fills
        v0 = 16'($urandom);
        v1 = 16'($urandom);
        fq0.push_back(v0);
        upd_empty();
        r0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("no_pop_partial", 32'(fifo_rd_en), 32'd0);
            chk("no_tx_partial", 32'(tx_valid), 32'd0);
        end
        fq1.push_back(v1);
        upd_empty();
        exp_payload(v0);
        exp_payload(v1);
        wait_exp("set_partial_done", 0, 100);
        chk("pop_once", 32'(rd_cnt - r0), 32'd1);

        // tx_ready low for 10 cycles mid-set: byte held, nothing lost, no extra pop
        mark = xfers;
        push_set(16'($urandom), 16'($urandom));
        exp_end();
        exp_header();
        wait_xfers("first_payload", mark + 1, 100);
        ready_mode = 2;
        tx_ready = 1'b0;
        r0 = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", 32'(tx_data), 32'(exp_q[0]));
        end
        chk("stall_no_pop", 32'(rd_cnt - r0), 32'd0);
        ready_mode = 0;
        tx_ready = 1'b1;
        wait_exp("frame1_done", 0, 200);
        chk("frame_cnt_2", 32'(frame_cnt), 32'(exp_fc));

        // stop after 3rd payload byte: frame finishes, no further header
        ready_mode = 1;
        push_set(16'($urandom), 16'($urandom));
        push_set(16'($urandom), 16'($urandom));
        exp_end();
        mark = xfers;
        wait_xfers("third_payload", mark + 3, 200);
        stop = 1'b1;
        cyc();
        wait_exp("frame2_done", 0, 300);
        repeat (6) cyc();
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_valid", 32'(tx_valid), 32'd0);
        chk("frame_cnt_3", 32'(frame_cnt), 32'(exp_fc));
        ready_mode = 0;

        // start and stop together from IDLE: stays idle
        start = 1'b1;
        stop = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ss_busy", 32'(busy), 32'd0);
            chk("ss_valid", 32'(tx_valid), 32'd0);
        end

        // Reset in the middle of a sample set
        exp_header();
        push_set(16'($urandom), 16'($urandom));
        start = 1'b1;
        mark = xfers;
        wait_xfers("mid_send", mark + 5, 200);
        sys_rst_n = 1'b0;
        #1;
        chk("mrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mrst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
        exp_q.delete();
        fq0.delete();
        fq1.delete();
        fifo_q = '0;
        upd_empty();
        exp_fc = '0;
        chk_acc = '0;
        have_prev = 1'b0;
        cyc();
        sys_rst_n = 1'b1;
        cyc();

        // Randomized multi-frame run with random backpressure, stop inside the last frame
        ready_mode = 1;
        exp_header();
        for (int f = 0; f < 3; f++) begin
            push_set(16'($urandom), 16'($urandom));
            push_set(16'($urandom), 16'($urandom));
            exp_end();
            if (f < 2) exp_header();
        end
        start = 1'b1;
        wait_exp("rand_reach_last", 5, 2000);
        stop = 1'b1;
        cyc();
        wait_exp("rand_done", 0, 500);
        repeat (6) cyc();
        chk("rand_busy", 32'(busy), 32'd0);
        chk("rand_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        chk("rand_fifos_drained", 32'(fq0.size() + fq1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
